// File: rtl/softmax_row_scheduler_if.sv
// Control, stream and softmax-datapath signals of the softmax row scheduler.
// The slave modport is the scheduler itself; master is its surrounding environment.
interface softmax_row_scheduler_if #(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH       = 4,
  parameter int NUM_ROWS          = 4
) ();
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic                                      start;
  logic                                      busy;
  logic                                      done;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [INPUT_DATA_WIDTH-1:0]               in_data;
  logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0]   sm_in;
  logic [OUTPUT_DATA_WIDTH*DATA_LENGTH-1:0]  sm_out;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [OUTPUT_DATA_WIDTH-1:0]              out_data;
  logic                                      out_last_elem;
  logic                                      out_last_row;
  logic [ROW_W-1:0]                          row_idx;

  modport slave (
    input  start, in_valid, in_data, sm_out, out_ready,
    output busy, done, in_ready, sm_in, out_valid, out_data,
           out_last_elem, out_last_row, row_idx
  );

  modport master (
    output start, in_valid, in_data, sm_out, out_ready,
    input  busy, done, in_ready, sm_in, out_valid, out_data,
           out_last_elem, out_last_row, row_idx
  );
endinterface

// File: rtl/softmax_row_scheduler.sv
// Row-at-a-time sequencer around the shared combinational softmax datapath:
// collect a row, capture the softmax result in one cycle, stream it back out.
module softmax_row_scheduler_chk #(
  parameter int OUTPUT_DATA_WIDTH = 16
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         busy,
  input logic                         done,
  input logic                         in_ready,
  input logic                         out_valid,
  input logic                         out_ready,
  input logic [OUTPUT_DATA_WIDTH-1:0] out_data
);
  a_no_overlap : assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));

  a_done_idle : assert property (@(posedge clk) disable iff (rst)
    done |-> !busy);

  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
endmodule

module softmax_row_scheduler #(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH       = 4,
  parameter int NUM_ROWS          = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  softmax_row_scheduler_if.slave bus
);
  localparam int COL_W = $clog2(DATA_LENGTH);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(DATA_LENGTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t                                   state_r;
  state_t                                   state_next_s;
  logic [COL_W-1:0]                         col_r;
  logic [COL_W-1:0]                         ocol_r;
  logic [ROW_W-1:0]                         row_r;
  logic                                     done_r;
  logic [INPUT_DATA_WIDTH-1:0]              row_mem_r [DATA_LENGTH];
  logic [OUTPUT_DATA_WIDTH-1:0]             result_r  [DATA_LENGTH];
  logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0]  sm_in_s;
  logic                                     load_hs_s;
  logic                                     drain_hs_s;
  logic                                     row_end_s;
  logic                                     matrix_end_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_next_s = state_r;
    load_hs_s    = 1'b0;
    drain_hs_s   = 1'b0;
    row_end_s    = 1'b0;
    matrix_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_hs_s = bus.in_valid;
        if (load_hs_s && (col_r == LAST_COL)) begin
          state_next_s = ST_COMPUTE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_COMPUTE: begin
        state_next_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_hs_s   = bus.out_ready;
        row_end_s    = drain_hs_s && (ocol_r == LAST_COL);
        matrix_end_s = row_end_s && (row_r == LAST_ROW);
        if (matrix_end_s) begin
          state_next_s = ST_IDLE;
        end else if (row_end_s) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Counters, row register, result buffer and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r  <= '0;
      ocol_r <= '0;
      row_r  <= '0;
      done_r <= 1'b0;
      for (int i = 0; i < DATA_LENGTH; i++) begin
        row_mem_r[i] <= '0;
        result_r[i]  <= '0;
      end
    end else begin
      done_r <= matrix_end_s;
      if ((state_r == ST_IDLE) && bus.start) begin
        row_r <= '0;
        col_r <= '0;
      end
      if (load_hs_s) begin
        row_mem_r[col_r] <= bus.in_data;
        col_r            <= (col_r == LAST_COL) ? '0 : col_r + COL_W'(1);
      end
      // The softmax datapath is combinational on sm_in, so one cycle suffices.
      if (state_r == ST_COMPUTE) begin
        ocol_r <= '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
          result_r[i] <= bus.sm_out[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
        end
      end
      if (drain_hs_s) begin
        ocol_r <= row_end_s ? '0 : ocol_r + COL_W'(1);
        if (matrix_end_s) begin
          row_r <= '0;
        end else if (row_end_s) begin
          row_r <= row_r + ROW_W'(1);
        end
      end
    end
  end

  // Pack the row register onto the softmax input bus
  always_comb begin
    sm_in_s = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      sm_in_s[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = row_mem_r[i];
    end
  end

  // Output decode from registered state
  always_comb begin
    bus.busy     = (state_r != ST_IDLE);
    bus.in_ready = (state_r == ST_LOAD);
    bus.done     = done_r;
    bus.row_idx  = row_r;
    bus.sm_in    = sm_in_s;
    if (state_r == ST_DRAIN) begin
      bus.out_valid     = 1'b1;
      bus.out_data      = result_r[ocol_r];
      bus.out_last_elem = (ocol_r == LAST_COL);
      bus.out_last_row  = (row_r == LAST_ROW);
    end else begin
      bus.out_valid     = 1'b0;
      bus.out_data      = '0;
      bus.out_last_elem = 1'b0;
      bus.out_last_row  = 1'b0;
    end
  end

  softmax_row_scheduler_chk #(
    .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .busy      (bus.busy),
    .done      (bus.done),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data)
  );
endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed bench for softmax_row_scheduler: a 4-row DUT and a 1-row DUT,
// each with a behavioural (x-min)^2 in 8.8 softmax model on sm_out.
module tb_softmax_row_scheduler;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int DL = 4;
  localparam int NR = 4;

  typedef struct packed {
    logic [DL-1:0][IW-1:0] x;
    logic [DL-1:0][OW-1:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  softmax_row_scheduler_if #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW),
                             .DATA_LENGTH(DL), .NUM_ROWS(NR)) a ();
  softmax_row_scheduler_if #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW),
                             .DATA_LENGTH(DL), .NUM_ROWS(1)) b ();

  softmax_row_scheduler #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW),
                          .DATA_LENGTH(DL), .NUM_ROWS(NR)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  softmax_row_scheduler #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW),
                          .DATA_LENGTH(DL), .NUM_ROWS(1)) u_dut_one (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  function automatic logic [63:0] sm_model(input logic [63:0] v);
    int          mn;
    int          d;
    logic [31:0] q;
    logic [63:0] r;
    mn = int'(v[15:0]);
    for (int i = 1; i < 4; i++) begin
      if (int'(v[16*i +: 16]) < mn) mn = int'(v[16*i +: 16]);
    end
    r = 64'd0;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[16*i +: 16]) - mn;
      q = 32'(d * d * 256);
      r[16*i +: 16] = q[15:0];
    end
    return r;
  endfunction

  always_comb a.sm_out = sm_model(a.sm_in);
  always_comb b.sm_out = sm_model(b.sm_in);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t                  tbl [NR];
    logic [DL-1:0][OW-1:0] rst_y;
    int in_cnt, out_cnt, k, done_cnt, cyc;

    tbl[0].x = {16'd3,   16'd9,   16'd3,   16'd5};
    tbl[0].y = {16'h0000, 16'h2400, 16'h0000, 16'h0400};
    tbl[1].x = {16'd10,  16'd11,  16'd12,  16'd10};
    tbl[1].y = {16'h0000, 16'h0100, 16'h0400, 16'h0000};
    tbl[2].x = {16'd7,   16'd7,   16'd7,   16'd7};
    tbl[2].y = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[3].x = {16'd103, 16'd101, 16'd98,  16'd100};
    tbl[3].y = {16'h1900, 16'h0900, 16'h0000, 16'h0400};
    rst_y    = {16'h0900, 16'h0400, 16'h0100, 16'h0000};

    a.start = 1'b0; a.in_valid = 1'b0; a.in_data = 16'd0; a.out_ready = 1'b0;
    b.start = 1'b0; b.in_valid = 1'b0; b.in_data = 16'd0; b.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",      64'(a.busy),          64'd0);
    check("rst_in_ready",  64'(a.in_ready),      64'd0);
    check("rst_out_valid", 64'(a.out_valid),     64'd0);
    check("rst_done",      64'(a.done),          64'd0);
    check("rst_sm_in",     a.sm_in,              64'd0);
    check("rst_last_row1", 64'(b.out_last_row),  64'd0);
    rst = 1'b0;

    // Single row on the NUM_ROWS=1 instance, no stalls
    @(negedge clk); b.start = 1'b1;
    @(negedge clk); b.start = 1'b0;
    check("one_load_ready", 64'(b.in_ready), 64'd1);
    for (int i = 0; i < DL; i++) begin
      b.in_valid = 1'b1;
      b.in_data  = tbl[0].x[i];
      @(negedge clk);
    end
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    check("one_sm_in",      b.sm_in,              64'h0003_0009_0003_0005);
    check("one_compute_ov", 64'(b.out_valid),     64'd0);
    for (int i = 0; i < DL; i++) begin
      @(negedge clk);
      check("one_out_valid", 64'(b.out_valid),     64'd1);
      check("one_out_data",  64'(b.out_data),      64'(tbl[0].y[i]));
      check("one_last_elem", 64'(b.out_last_elem), (i == DL - 1) ? 64'd1 : 64'd0);
      check("one_last_row",  64'(b.out_last_row),  64'd1);
      check("one_no_done",   64'(b.done),          64'd0);
    end
    @(negedge clk);
    check("one_done",      64'(b.done), 64'd1);
    check("one_idle",      64'(b.busy), 64'd0);
    @(negedge clk);
    check("one_done_once", 64'(b.done), 64'd0);

    // Full matrix with random input gaps and out_ready 1,0,0,1 backpressure; start held high
    in_cnt = 0; out_cnt = 0; k = 0; done_cnt = 0;
    a.start = 1'b1;
    for (cyc = 0; cyc < 2000 && out_cnt < NR * DL; cyc++) begin
      @(negedge clk);
      if (a.done) done_cnt++;
      if (in_cnt < NR * DL) begin
        a.in_valid = ($urandom_range(0, 2) != 0);
        a.in_data  = tbl[in_cnt / DL].x[in_cnt % DL];
      end else begin
        a.in_valid = 1'b0;
        a.in_data  = 16'd0;
      end
      a.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      if (a.in_valid && a.in_ready) in_cnt++;
      if (a.busy && !a.in_ready && !a.out_valid) begin
        check("mat_sm_in", a.sm_in, tbl[out_cnt / DL].x);
      end
      if (a.out_valid) begin
        check("mat_drain_in_ready", 64'(a.in_ready), 64'd0);
        check("mat_out_data", 64'(a.out_data), 64'(tbl[out_cnt / DL].y[out_cnt % DL]));
        if (a.out_ready) begin
          check("mat_last_elem", 64'(a.out_last_elem), ((out_cnt % DL) == DL - 1) ? 64'd1 : 64'd0);
          check("mat_last_row",  64'(a.out_last_row),  ((out_cnt / DL) == NR - 1) ? 64'd1 : 64'd0);
          check("mat_row_idx",   64'(a.row_idx),       64'(out_cnt / DL));
          out_cnt++;
        end
        k++;
      end
    end
    check("mat_handshakes", 64'(out_cnt),  64'(NR * DL));
    check("mat_done_early", 64'(done_cnt), 64'd0);
    @(negedge clk);
    check("mat_done",       64'(a.done), 64'd1);
    check("mat_done_idle",  64'(a.busy), 64'd0);
    @(negedge clk);
    a.start = 1'b0;
    check("restart_busy",     64'(a.busy),     64'd1);
    check("restart_row_idx",  64'(a.row_idx),  64'd0);
    check("restart_in_ready", 64'(a.in_ready), 64'd1);
    check("restart_no_done",  64'(a.done),     64'd0);

    // Reset mid-load after two handshakes
    a.in_valid = 1'b1; a.in_data = 16'hAAAA;
    @(negedge clk);
    a.in_data = 16'hBBBB;
    @(negedge clk);
    a.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",     64'(a.busy),     64'd0);
    check("mid_rst_in_ready", 64'(a.in_ready), 64'd0);
    check("mid_rst_sm_in",    a.sm_in,         64'd0);
    check("mid_rst_row_idx",  64'(a.row_idx),  64'd0);
    check("mid_rst_out_data", 64'(a.out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_no_done", 64'(a.done), 64'd0);
    a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    for (int i = 0; i < DL; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = 16'(i + 1);
      @(negedge clk);
    end
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    check("clean_sm_in",     a.sm_in,          64'h0004_0003_0002_0001);
    check("clean_compute",   64'(a.out_valid), 64'd0);
    for (int i = 0; i < DL; i++) begin
      @(negedge clk);
      check("clean_out_data", 64'(a.out_data),     64'(rst_y[i]));
      check("clean_last_row", 64'(a.out_last_row), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/softmax_row_scheduler.md
Name: softmax_row_scheduler

Overview:
Sequences the shared combinational softmax datapath (row-wise (x-min)^2 plus quantization) over a score matrix of NUM_ROWS rows.
- Collects one row of DATA_LENGTH elements from an element-serial valid/ready stream.
- Presents the packed row to the softmax unit and captures its packed result.
- Streams the results out element-serially. Sits between the score (QK^T) producer and the value-multiply stage of the attention module.

Parameters:
INPUT_DATA_WIDTH, 16, width of one input score element
OUTPUT_DATA_WIDTH, 16, width of one softmax output element (8.8 fixed point)
DATA_LENGTH, 4, elements per row (softmax vector length), >=2
NUM_ROWS, 4, rows per matrix (start-to-done), >=1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a matrix; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after last element of last row handshakes
in_valid  input  1  input element valid
in_ready  output  1  scheduler accepts input element
in_data  input  INPUT_DATA_WIDTH  input score element, row order element 0 first
sm_in  output  INPUT_DATA_WIDTH*DATA_LENGTH  packed row to softmax unit; element i at bits [IW*(i+1)-1 : IW*i]
sm_out  input  OUTPUT_DATA_WIDTH*DATA_LENGTH  packed softmax result, same packing with OW
out_valid  output  1  output element valid
out_ready  input  1  downstream accepts output element
out_data  output  OUTPUT_DATA_WIDTH  output element
out_last_elem  output  1  out_data is element DATA_LENGTH-1 of the row
out_last_row  output  1  current output row is row NUM_ROWS-1
row_idx  output  max(1,$clog2(NUM_ROWS))  index of row being loaded/drained

Behaviour:
- Reset (async, any state): state=IDLE; row, col, ocol counters=0; row register and result buffer=0. All outputs 0, including sm_in. Partial row and undrained results are discarded; done is not pulsed.
- States: IDLE, LOAD, COMPUTE, DRAIN. One row in flight; no load/drain overlap.
- IDLE: in_ready=0, out_valid=0. On start=1, go to LOAD with row=0, col=0. Start is ignored in all other states.
- LOAD: in_ready=1.
  - On in_valid&in_ready, in_data is written to row-register slot col.
  - If col==DATA_LENGTH-1: col=0 and go to COMPUTE; otherwise col++.
  - in_valid=0 stalls indefinitely.
- sm_in is driven directly from the row register, so it is stable from COMPUTE through DRAIN.
- COMPUTE: exactly one cycle. in_ready=0, out_valid=0. Result buffer <= sm_out (combinational path settles within that cycle), ocol=0, then DRAIN.
- DRAIN:
  - out_valid=1, out_data=buffer[ocol], out_last_elem=(ocol==DATA_LENGTH-1), out_last_row=(row==NUM_ROWS-1). in_ready=0.
  - On out_valid&out_ready: ocol++.
  - At the last element handshake: if last row, go to IDLE and pulse done next cycle; else row++ and go to LOAD.
  - out_data/out_valid hold stable while out_ready=0.
- done is registered: high in the first IDLE cycle after the final handshake. A start in that same cycle is accepted.
- Latency (no stalls): last input handshake at cycle t; COMPUTE at t+1; first out_valid at t+2; row drained by t+1+DATA_LENGTH.
- Minimum matrix time: NUM_ROWS*(2*DATA_LENGTH+1) cycles.
- row_idx = row counter; it wraps only via the return to IDLE.
- NUM_ROWS=1: done follows the first row's drain.
- No arithmetic is done in this block; widths pass through unchanged.

Test Plan:
- Reset mid-operation: DL=4, NR=4, after 2 input handshakes assert rst -> all outputs 0, state IDLE. A new start plus 4 elements loads a clean row, and no stale element appears in sm_in.
- Single row, no stalls (NR=1), in_data 5,3,9,3 -> sm_in={16'd3,16'd9,16'd3,16'd5}. Bench model drives sm_out={16'h0000,16'h2400,16'h0000,16'h0400}. Required: out_data 0x0400,0x0000,0x2400,0x0000 on cycles t+2..t+5, out_last_elem on the 4th element, done one cycle later.
- Backpressure: out_ready toggled 1,0,0,1,... -> each element held until handshake, no duplicates or drops. in_ready stays 0 throughout DRAIN.
- Full matrix NR=4 with random in_valid gaps -> row_idx 0..3 in order, out_last_row only on row 3, exactly 16 output handshakes, done asserted exactly once.
- Start during busy -> ignored, no counter change. Start coincident with the done cycle -> accepted, busy=1 next cycle, row_idx=0.
